// File: rtl/iobuf_bus_ctrl_pkg.sv
// Shared types and widths for the half-duplex pad bus controller.
package iobuf_bus_ctrl_pkg;

    // Bus direction / phase of the controller
    typedef enum logic [2:0] {
        IDLE_RX,
        TURN_TX,
        DRIVE,
        HOLD,
        TURN_RX
    } state_e;

    // Turnaround counter covers TURN values 1..15
    localparam int TURN_CNT_W  = 4;
    // Burst counter covers MAX_BURST values 1..255
    localparam int BURST_CNT_W = 8;
    // Width of the dropped-strobe counter output
    localparam int DROP_CNT_W  = 8;

endpackage

// File: rtl/iobuf_bus_sync.sv
// Synchronizer for the asynchronous remote data/strobe plus a registered
// rising-edge detector on the synchronized strobe.
module iobuf_bus_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_o,
    input  logic             pad_stb,
    output logic [WIDTH-1:0] data_sync,
    output logic             stb_edge
);

    logic [SYNC_STAGES-1:0]            stb_q, stb_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] dat_q, dat_d;
    logic                              stb_prev_q, stb_prev_d;
    logic                              edge_q, edge_d;

    // Shift both chains by one stage and flag a low-to-high synced strobe
    // NOTE: every signal written here gets a value on every path (here by
    // direct assignment); a path that leaves one unassigned infers a latch.
    always_comb begin
        stb_d      = {stb_q[SYNC_STAGES-2:0], pad_stb};
        dat_d      = {dat_q[SYNC_STAGES-2:0], pad_o};
        stb_prev_d = stb_q[SYNC_STAGES-1];
        edge_d     = stb_q[SYNC_STAGES-1] & ~stb_prev_q;
    end

    // Synchronizer, edge history and registered edge pulse
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // the whole chain is reset (not left as an unreset array) so no stale
    // strobe can fake an edge right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q      <= '0;
            dat_q      <= '0;
            stb_prev_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            stb_q      <= stb_d;
            dat_q      <= dat_d;
            stb_prev_q <= stb_prev_d;
            edge_q     <= edge_d;
        end
    end

    assign data_sync = dat_q[SYNC_STAGES-1];
    assign stb_edge  = edge_q;

endmodule

// File: rtl/iobuf_bus_ctrl.sv
// Half-duplex pad bus controller: transmits valid/ready words in bursts of at
// most MAX_BURST with TURN released cycles at each direction change, and
// captures strobed remote words while idle.
// Optional: define IOBUF_BUS_CTRL_DROPCNT_EN to count strobes dropped while busy.
module iobuf_bus_ctrl
    import iobuf_bus_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_BURST   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic [7:0]       drop_cnt,
    output logic [WIDTH-1:0] pad_i,
    output logic             pad_t,
    input  logic [WIDTH-1:0] pad_o,
    input  logic             pad_stb
);

    state_e                  state_q, state_d;
    logic [TURN_CNT_W-1:0]   turn_q, turn_d;
    logic [BURST_CNT_W-1:0]  burst_q, burst_d;
    logic [WIDTH-1:0]        pad_i_q, pad_i_d;
    logic                    pad_t_q, pad_t_d;
    logic [WIDTH-1:0]        rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0]        data_sync;
    logic                    sync_edge;

    iobuf_bus_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .pad_o     (pad_o),
        .pad_stb   (pad_stb),
        .data_sync (data_sync),
        .stb_edge  (sync_edge)
    );

    // Bus direction FSM, turnaround/burst counters and pad drive
    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        burst_d = burst_q;
        pad_i_d = pad_i_q;
        pad_t_d = pad_t_q;
        case (state_q)
            IDLE_RX: begin
                pad_t_d = 1'b1;
                if (tx_valid) begin
                    state_d = TURN_TX;
                    turn_d  = TURN_CNT_W'(TURN);
                end
            end
            TURN_TX: begin
                pad_t_d = 1'b1;
                if (turn_q == TURN_CNT_W'(1)) begin
                    state_d = DRIVE;
                    burst_d = '0;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            DRIVE: begin
                if (tx_valid) begin
                    pad_i_d = tx_data;
                    pad_t_d = 1'b0;
                    burst_d = burst_q + 1'b1;
                    // Cut the burst so the remote is guaranteed an idle slot
                    if (burst_q + 1'b1 == BURST_CNT_W'(MAX_BURST)) begin
                        state_d = HOLD;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Last word stays on the pads this cycle; release from next
                pad_t_d = 1'b1;
                state_d = TURN_RX;
                turn_d  = TURN_CNT_W'(TURN);
            end
            TURN_RX: begin
                pad_t_d = 1'b1;
                if (turn_q == TURN_CNT_W'(1)) begin
                    state_d = IDLE_RX;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE_RX;
                pad_t_d = 1'b1;
            end
        endcase
    end

    // Capture a remote word only while idle; edges elsewhere are discarded
    always_comb begin
        rx_valid_d = sync_edge && (state_q == IDLE_RX);
        rx_data_d  = rx_valid_d ? data_sync : rx_data_q;
    end

    // Controller state and pad registers; reset releases the bus immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE_RX;
            turn_q     <= '0;
            burst_q    <= '0;
            pad_i_q    <= '0;
            pad_t_q    <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            burst_q    <= burst_d;
            pad_i_q    <= pad_i_d;
            pad_t_q    <= pad_t_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef IOBUF_BUS_CTRL_DROPCNT_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    // Saturating count of strobe edges seen outside IDLE_RX
    always_comb begin
        drop_d = drop_q;
        if (sync_edge && (state_q != IDLE_RX) && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Drop counter register; cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

    assign tx_ready = (state_q == DRIVE);
    assign busy     = (state_q != IDLE_RX);
    assign pad_i    = pad_i_q;
    assign pad_t    = pad_t_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_iobuf_bus_ctrl.sv
// Self-checking bench for iobuf_bus_ctrl (default parameters). Optional
// drop-counter expectations follow IOBUF_BUS_CTRL_DROPCNT_EN.
module tb_iobuf_bus_ctrl;

    localparam int WIDTH       = 8;
    localparam int TURN        = 2;
    localparam int SYNC_STAGES = 2;
    localparam int MAX_BURST   = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    logic [7:0]       drop_cnt;
    logic [WIDTH-1:0] pad_i;
    logic             pad_t;
    logic [WIDTH-1:0] pad_o;
    logic             pad_stb;

    iobuf_bus_ctrl #(
        .WIDTH       (WIDTH),
        .TURN        (TURN),
        .SYNC_STAGES (SYNC_STAGES),
        .MAX_BURST   (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .drop_cnt (drop_cnt),
        .pad_i    (pad_i),
        .pad_t    (pad_t),
        .pad_o    (pad_o),
        .pad_stb  (pad_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       tx_valid;
        logic [7:0] tx_data;
        logic       exp_pad_t;
        logic [7:0] exp_pad_i;
        logic       care_pad_i;
        logic       exp_ready;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [10];

    int n_checks = 0;
    int n_errors = 0;

    // Bus-level reference model state
    bit         bus_mon = 0;
    bit         rx_mon  = 0;
    bit         last_hs = 0;
    logic       pad_t_prev = 1'b1;
    int         rel_run = 0;
    bit         seen_fall = 0;
    int         burst_n = 0;
    bit         seen_burst = 0;
    bit         idle_seen = 1;
    int         bursts_q [$];
    logic [7:0] rx_exp_q [$];
    int         rx_got = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_trackers();
        pad_t_prev = pad_t;
        rel_run    = 0;
        seen_fall  = 0;
        burst_n    = 0;
        seen_burst = 0;
        idle_seen  = 1;
        bursts_q.delete();
    endtask

    // Advance one cycle; sample 1 time unit after the rising edge and run
    // the bus / receive models on what the cycle produced.
    task automatic tick();
        bit         hs;
        logic [7:0] d;
        hs = tx_valid && tx_ready;
        d  = tx_data;
        @(posedge clk);
        #1;
        last_hs = hs;
        if (bus_mon) begin
            if (hs) begin
                if (burst_n == 0 && seen_burst)
                    check("idle_between_bursts", 32'(idle_seen), 1);
                check("bus_driven_after_hs", 32'(pad_t), 0);
                check("bus_word", 32'(pad_i), 32'(d));
                burst_n++;
            end
            if (pad_t && !pad_t_prev) begin
                check("burst_len_le_max", 32'(burst_n <= MAX_BURST), 1);
                bursts_q.push_back(burst_n);
                burst_n    = 0;
                seen_burst = 1;
                idle_seen  = 0;
            end
            if (!pad_t && pad_t_prev) begin
                if (seen_fall)
                    check("release_gap", 32'(rel_run >= 2 * TURN + 2), 1);
                seen_fall = 1;
                rel_run   = 0;
            end
            if (pad_t) rel_run++;
            if (!busy) idle_seen = 1;
            pad_t_prev = pad_t;
        end
        if (rx_mon && rx_valid) begin
            if (rx_exp_q.size() == 0) begin
                check("rx_unexpected", 32'(rx_valid), 0);
            end else begin
                check("rx_word", 32'(rx_data), 32'(rx_exp_q.pop_front()));
                rx_got++;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 0);
    endtask

    task automatic send_word(input logic [7:0] d);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        last_hs  = 0;
        while (!last_hs && n < 50) begin
            tick();
            n++;
        end
        check("send_word_hs", 32'(last_hs), 1);
        tx_valid = 1'b0;
    endtask

    initial begin
        int         idx;
        int         n;
        int         pulses;
        int         sent;
        int         rxv;
        logic [7:0] d;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        pad_o    = '0;
        pad_stb  = 1'b0;

        // Single word 0xA5 starting at cycle 0
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pad_t", 32'(pad_t), 1);
        check("rst_pad_i", 32'(pad_i), 0);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Table-driven single-word transaction
        for (int i = 0; i < 10; i++) begin
            tx_valid = vecs[i].tx_valid;
            tx_data  = vecs[i].tx_data;
            check($sformatf("vec%0d_pad_t", i), 32'(pad_t), 32'(vecs[i].exp_pad_t));
            if (vecs[i].care_pad_i)
                check($sformatf("vec%0d_pad_i", i), 32'(pad_i), 32'(vecs[i].exp_pad_i));
            check($sformatf("vec%0d_ready", i), 32'(tx_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            tick();
        end

        // 20 continuous words: expect bursts of 16 then 4
        bus_mon = 1;
        reset_trackers();
        idx = 0;
        n   = 0;
        while (idx < 20 && n < 300) begin
            tx_valid = 1'b1;
            tx_data  = 8'(8'h40 + idx);
            tick();
            if (last_hs) idx++;
            n++;
        end
        tx_valid = 1'b0;
        check("w20_all_sent", 32'(idx), 20);
        wait_idle("w20_idle");
        check("w20_burst_count", 32'(bursts_q.size()), 2);
        if (bursts_q.size() >= 2) begin
            check("w20_burst0", 32'(bursts_q[0]), 16);
            check("w20_burst1", 32'(bursts_q[1]), 4);
        end

        // Reset asserted mid-DRIVE releases the bus before the next edge
        bus_mon  = 0;
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        sent     = 0;
        n        = 0;
        while (sent < 2 && n < 50) begin
            tick();
            if (last_hs) begin
                sent++;
                tx_data = 8'h12;
            end
            n++;
        end
        check("mid_drive_driving", 32'(pad_t), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_drive_rst_pad_t", 32'(pad_t), 1);
        check("mid_drive_rst_ready", 32'(tx_ready), 0);
        check("mid_drive_rst_busy", 32'(busy), 0);
        tx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Strobe 0x3C held 3 cycles: one RX_VALID, 3 cycles after sampling
        pad_o = 8'h3C;
        tick();
        pad_stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("rx3c_valid_k%0d", k), 32'(rx_valid), 32'(k == 4));
            if (k == 4) check("rx3c_data", 32'(rx_data), 'h3C);
            if (k == 3) pad_stb = 1'b0;
        end

        // Strobe held high 10 cycles: single capture
        pad_o = 8'hC3;
        tick();
        pad_stb = 1'b1;
        pulses  = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (rx_valid) pulses++;
            if (k == 10) pad_stb = 1'b0;
        end
        check("long_stb_pulses", 32'(pulses), 1);
        check("long_stb_data", 32'(rx_data), 'hC3);

        // Two strobe edges while driving: both dropped
        bus_mon = 1;
        reset_trackers();
        tx_valid = 1'b1;
        tx_data  = 8'h10;
        n = 0;
        while (!tx_ready && n < 20) begin
            tick();
            n++;
        end
        check("drv_reached", 32'(tx_ready), 1);
        sent = 0;
        rxv  = 0;
        for (int j = 0; j < 30; j++) begin
            pad_stb  = (j == 0 || j == 1 || j == 5 || j == 6);
            tx_valid = (sent < 16);
            tick();
            if (last_hs) begin
                sent++;
                tx_data = 8'(8'h10 + sent);
            end
            if (rx_valid) rxv++;
        end
        pad_stb  = 1'b0;
        tx_valid = 1'b0;
        check("drv_drop_sent", 32'(sent), 16);
        check("drv_drop_no_rx", 32'(rxv), 0);
`ifdef IOBUF_BUS_CTRL_DROPCNT_EN
        check("drv_drop_cnt", 32'(drop_cnt), 2);
`else
        check("drv_drop_cnt", 32'(drop_cnt), 0);
`endif
        wait_idle("drv_drop_idle");

        // TX_VALID and strobe edge in the same IDLE_RX cycle
        pad_o = 8'h5A;
        tick();
        pad_stb = 1'b1;
        repeat (3) tick();
        pad_stb = 1'b0;
        check("same_cycle_idle", 32'(busy), 0);
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        tick();
        check("same_cycle_rx_valid", 32'(rx_valid), 1);
        check("same_cycle_rx_data", 32'(rx_data), 'h5A);
        check("same_cycle_turn_tx", 32'(busy), 1);
        check("same_cycle_bus_released", 32'(pad_t), 1);
        send_word(8'h77);
        wait_idle("same_cycle_idle_after");

        // Randomized transmit traffic against the bus-level model
        reset_trackers();
        for (int c = 0; c < 1500; c++) begin
            if (!tx_valid || last_hs) begin
                tx_valid = ($urandom_range(0, 3) != 0);
                tx_data  = 8'($urandom);
            end
            tick();
        end
        tx_valid = 1'b0;
        wait_idle("rand_tx_idle");
        tick();

        // Randomized receive traffic against a queue of sent words
        rx_mon = 1;
        rx_exp_q.delete();
        rx_got = 0;
        for (int i = 0; i < 20; i++) begin
            d     = 8'($urandom);
            pad_o = d;
            tick();
            pad_stb = 1'b1;
            rx_exp_q.push_back(d);
            repeat ($urandom_range(1, 4)) tick();
            pad_stb = 1'b0;
            repeat ($urandom_range(3, 6)) tick();
        end
        repeat (6) tick();
        check("rand_rx_count", 32'(rx_got), 20);
        check("rand_rx_queue_empty", 32'(rx_exp_q.size()), 0);
        rx_mon = 0;

        // Sustained strobes during continuous transmit: counter saturation
        for (int j = 0; j < 2000; j++) begin
            pad_stb = ((j % 4) < 2);
            if (!tx_valid || last_hs) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
            end
            tick();
        end
        pad_stb  = 1'b0;
        tx_valid = 1'b0;
        wait_idle("sat_idle");
        repeat (5) tick();
`ifdef IOBUF_BUS_CTRL_DROPCNT_EN
        check("drop_cnt_saturated", 32'(drop_cnt), 255);
`else
        check("drop_cnt_tied_zero", 32'(drop_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
